// File: rtl/act_pkg.sv
// Shared types and constants for the activation unit.
// No logic; types only.
// Not applicable.
package act_pkg;

    // Activation function selected per beat.
    typedef enum logic [1:0] {
        RELU   = 2'd0,
        LEAKY  = 2'd1,
        CLAMP  = 2'd2,
        BYPASS = 2'd3
    } act_mode_e;

    // Width of the saturation event counter.
    localparam int SAT_CNT_W = 16;

endpackage

// File: rtl/act_lane.sv
// One lane of activation followed by signed saturation to the output width.
// Purely combinational, zero latency.
// No flow control; the caller owns the handshake.
module act_lane
    import act_pkg::*;
#(
    parameter int IN_W    = 21,
    parameter int OUT_W   = 13,
    parameter int LEAK_SH = 3
) (
    input  logic signed [IN_W-1:0]  x,
    input  act_mode_e               mode,
    input  logic        [OUT_W-2:0] clamp_val,
    output logic signed [OUT_W-1:0] y,
    output logic                    sat
);

    // Output range limits expressed at the full input width so the comparison
    // sees every upper bit of the activation result.
    localparam logic signed [IN_W-1:0] Y_MAX = {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [IN_W-1:0] Y_MIN = {{(IN_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    logic signed [IN_W-1:0] act;
    logic signed [IN_W-1:0] clamp_ext;
    logic signed [IN_W-1:0] shifted;

    // The clamp ceiling is unsigned and narrower than the output, so a CLAMP
    // result can never reach the saturation limits.
    assign clamp_ext = signed'({{(IN_W-OUT_W+1){1'b0}}, clamp_val});
    assign shifted   = x >>> LEAK_SH;

    // Activation function at full input width.
    always_comb begin
        act = x;
        case (mode)
            RELU:    act = x[IN_W-1] ? '0 : x;
            LEAKY:   act = x[IN_W-1] ? shifted : x;
            CLAMP: begin
                if (x[IN_W-1])          act = '0;
                else if (x > clamp_ext) act = clamp_ext;
                else                    act = x;
            end
            BYPASS:  act = x;
            default: act = x;
        endcase
    end

    // Saturate to the output range and flag when the limit was applied.
    always_comb begin
        y   = act[OUT_W-1:0];
        sat = 1'b0;
        if (act > Y_MAX) begin
            y   = Y_MAX[OUT_W-1:0];
            sat = 1'b1;
        end else if (act < Y_MIN) begin
            y   = Y_MIN[OUT_W-1:0];
            sat = 1'b1;
        end
    end

endmodule

// File: rtl/act_unit.sv
// Multi-lane activation unit with per-lane saturation flags and event counter.
// Two register stages: output valid two cycles after the input transfer.
// Valid/ready; a stage loads when empty or draining, so in_ready drops only with both stages full and out_ready low.
module act_unit
    import act_pkg::*;
#(
    parameter int N_CH    = 4,
    parameter int IN_W    = 21,
    parameter int OUT_W   = 13,
    parameter int LEAK_SH = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [N_CH*IN_W-1:0]       in_data,
    input  act_mode_e                  mode,
    input  logic [OUT_W-2:0]           clamp_val,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [N_CH*OUT_W-1:0]      out_data,
    output logic [N_CH-1:0]            out_sat,
    output logic [SAT_CNT_W-1:0]       sat_cnt,
    input  logic                       sat_clr
);

    if (OUT_W > IN_W) begin : g_bad_width
        $error("act_unit: OUT_W must not exceed IN_W");
    end

    logic                   s1_vld;
    logic [N_CH*IN_W-1:0]   s1_dat;
    act_mode_e              s1_mode;
    logic [OUT_W-2:0]       s1_clamp;

    logic [N_CH*OUT_W-1:0]  lane_y;
    logic [N_CH-1:0]        lane_sat;

    logic                   s2_adv;
    logic                   sat_inc;

    // Stage 2 moves when it is empty or the consumer takes its beat; stage 1
    // may then refill in the same cycle. in_valid never feeds in_ready.
    assign s2_adv   = !out_valid || out_ready;
    assign in_ready = !s1_vld || s2_adv;
    assign sat_inc  = out_valid && out_ready && (|out_sat);

    // Stage 1: capture the beat together with the mode and clamp it was sent with.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld   <= 1'b0;
            s1_dat   <= '0;
            s1_mode  <= RELU;
            s1_clamp <= '0;
        end else if (in_ready) begin
            s1_vld <= in_valid;
            if (in_valid) begin
                s1_dat   <= in_data;
                s1_mode  <= mode;
                s1_clamp <= clamp_val;
            end
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_lane
        act_lane #(
            .IN_W    (IN_W),
            .OUT_W   (OUT_W),
            .LEAK_SH (LEAK_SH)
        ) u_lane (
            .x         (s1_dat[i*IN_W +: IN_W]),
            .mode      (s1_mode),
            .clamp_val (s1_clamp),
            .y         (lane_y[i*OUT_W +: OUT_W]),
            .sat       (lane_sat[i])
        );
    end

    // Stage 2: register lane results; hold everything while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= '0;
        end else if (s2_adv) begin
            out_valid <= s1_vld;
            if (s1_vld) begin
                out_data <= lane_y;
                out_sat  <= lane_sat;
            end
        end
    end

    // Count delivered beats with any saturated lane; sticks at all-ones, and a
    // clear coinciding with a counted beat leaves exactly that one beat counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_cnt <= '0;
        end else if (sat_clr) begin
            sat_cnt <= sat_inc ? SAT_CNT_W'(1) : '0;
        end else if (sat_inc && (sat_cnt != '1)) begin
            sat_cnt <= sat_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_act_unit.sv
// Self-checking bench for act_unit: table vectors, hand sequences and random traffic.
// Expected results come from an arithmetic reference model and a beat scoreboard.
// Backpressure exercised by toggling out_ready.
module tb_act_unit;
    import act_pkg::*;

    localparam int N_CH    = 4;
    localparam int IN_W    = 21;
    localparam int OUT_W   = 13;
    localparam int LEAK_SH = 3;
    localparam int OMAX    = (1 << (OUT_W-1)) - 1;
    localparam int OMIN    = -(1 << (OUT_W-1));

    logic                  clk;
    logic                  rst_n;
    logic                  in_valid;
    logic                  in_ready;
    logic [N_CH*IN_W-1:0]  in_data;
    act_mode_e             mode;
    logic [OUT_W-2:0]      clamp_val;
    logic                  out_valid;
    logic                  out_ready;
    logic [N_CH*OUT_W-1:0] out_data;
    logic [N_CH-1:0]       out_sat;
    logic [15:0]           sat_cnt;
    logic                  sat_clr;

    act_unit #(
        .N_CH(N_CH), .IN_W(IN_W), .OUT_W(OUT_W), .LEAK_SH(LEAK_SH)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .mode(mode), .clamp_val(clamp_val),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_sat(out_sat),
        .sat_cnt(sat_cnt), .sat_clr(sat_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [N_CH*OUT_W-1:0] d;
        logic [N_CH-1:0]       s;
    } exp_t;

    typedef struct {
        int             m;
        int             c;
        int             x [N_CH];
        int             y [N_CH];
        logic [N_CH-1:0] s;
    } vec_t;

    exp_t exp_q [$];
    exp_t next_exp;
    vec_t tbl [$];
    int   errors = 0;
    int   checks = 0;
    int   model_cnt = 0;

    task automatic check(string name, logic [63:0] got, logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, got, want, $time);
        end
    endtask

    // Reference activation from the arithmetic definitions; floor division
    // stands in for the arithmetic shift.
    function automatic int act_ref(int x, int m, int c, output bit s);
        int y;
        int d;
        d = 1 << LEAK_SH;
        case (m)
            0:       y = (x < 0) ? 0 : x;
            1:       y = (x >= 0) ? x : (x - (d - 1)) / d;
            2:       begin y = (x < 0) ? 0 : x; if (y > c) y = c; end
            default: y = x;
        endcase
        s = 1'b0;
        if (y > OMAX) begin y = OMAX; s = 1'b1; end
        else if (y < OMIN) begin y = OMIN; s = 1'b1; end
        return y;
    endfunction

    task automatic set_beat(int m, int c, int x0, int x1, int x2, int x3);
        int xs [N_CH];
        int y;
        bit s;
        xs = '{x0, x1, x2, x3};
        for (int i = 0; i < N_CH; i++) begin
            in_data[i*IN_W +: IN_W] = xs[i][IN_W-1:0];
            y = act_ref(xs[i], m, c, s);
            next_exp.d[i*OUT_W +: OUT_W] = y[OUT_W-1:0];
            next_exp.s[i] = s;
        end
        mode      = act_mode_e'(m);
        clamp_val = c[OUT_W-2:0];
    endtask

    task automatic add_vec(int m, int c, int x0, int x1, int x2, int x3,
                           int y0, int y1, int y2, int y3, logic [N_CH-1:0] s);
        vec_t v;
        v.m = m; v.c = c; v.s = s;
        v.x[0] = x0; v.x[1] = x1; v.x[2] = x2; v.x[3] = x3;
        v.y[0] = y0; v.y[1] = y1; v.y[2] = y2; v.y[3] = y3;
        tbl.push_back(v);
    endtask

    task automatic apply_vec(int i);
        set_beat(tbl[i].m, tbl[i].c, tbl[i].x[0], tbl[i].x[1], tbl[i].x[2], tbl[i].x[3]);
        for (int k = 0; k < N_CH; k++) begin
            next_exp.d[k*OUT_W +: OUT_W] = tbl[i].y[k][OUT_W-1:0];
        end
        next_exp.s = tbl[i].s;
    endtask

    function automatic int rnd_x();
        int v;
        case ($urandom_range(0, 2))
            0:       v = int'($urandom_range(0, 200)) - 100;
            1:       v = int'($urandom_range(0, 20000)) - 10000;
            default: begin v = int'($urandom); v = (v <<< (32-IN_W)) >>> (32-IN_W); end
        endcase
        return v;
    endfunction

    // One clock: sample handshakes at the falling edge, score the output beat,
    // then check hold-while-stalled and the counter after the rising edge.
    task automatic tick(output bit in_x);
        bit ix, ox, stalled, inc;
        logic [N_CH*OUT_W-1:0] hd;
        logic [N_CH-1:0] hs;
        exp_t e;
        @(negedge clk);
        check("in_ready", in_ready, !(exp_q.size() == 2 && !out_ready));
        ix = in_valid && in_ready;
        ox = out_valid && out_ready;
        stalled = out_valid && !out_ready;
        hd = out_data;
        hs = out_sat;
        inc = 1'b0;
        if (ox) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: got data %0h with nothing outstanding", out_data);
            end else begin
                e = exp_q.pop_front();
                check("out_data", out_data, e.d);
                check("out_sat", out_sat, e.s);
                inc = (e.s != '0);
            end
        end
        if (sat_clr) model_cnt = inc ? 1 : 0;
        else if (inc && model_cnt < 65535) model_cnt++;
        if (ix) exp_q.push_back(next_exp);
        @(posedge clk);
        #1;
        if (stalled) begin
            check("hold_valid", out_valid, 1);
            check("hold_data", out_data, hd);
            check("hold_sat", out_sat, hs);
        end
        check("sat_cnt", sat_cnt, model_cnt);
        in_x = ix;
    endtask

    task automatic drain(string name);
        bit ix;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) tick(ix);
        check(name, exp_q.size(), 0);
    endtask

    initial begin
        bit ix;
        int sent;
        int cyc;
        bit pat [4];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};

        add_vec(0, 0,    -7, 0, 100, 5000,          0, 0, 100, 4095,     4'b1000);
        add_vec(1, 0,    -100, -1, 8, -40000,       -13, -1, 8, -4096,   4'b1000);
        add_vec(2, 255,  300, -5, 255, 9000,        255, 0, 255, 255,    4'b0000);
        add_vec(3, 0,    -4096, 4095, -4097, 4096,  -4096, 4095, -4096, 4095, 4'b1100);
        add_vec(3, 0,    1048575, -1048576, 8191, -1, 4095, -4096, 4095, -1, 4'b0111);
        add_vec(0, 0,    8192, -1048576, 4095, 1,   4095, 0, 4095, 1,    4'b0001);
        add_vec(1, 0,    -32768, -32776, 7, -9,     -4096, -4096, 7, -2, 4'b0010);
        add_vec(2, 4095, 8191, 4095, -1048576, 100, 4095, 4095, 0, 100,  4'b0000);
        add_vec(2, 0,    5, -5, 0, 1048575,         0, 0, 0, 0,          4'b0000);

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; sat_clr = 1'b0;
        in_data = '0; mode = RELU; clamp_val = '0;
        next_exp.d = '0; next_exp.s = '0;

        // Reset state.
        #12;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_sat", out_sat, 0);
        check("rst_sat_cnt", sat_cnt, 0);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;

        // First beat: exact two-cycle latency, counter reaches 1.
        apply_vec(0);
        in_valid = 1'b1;
        tick(ix);
        in_valid = 1'b0;
        check("lat_cycle1_valid", out_valid, 0);
        tick(ix);
        check("lat_cycle2_valid", out_valid, 1);
        tick(ix);
        check("first_sat_cnt", sat_cnt, 1);
        drain("drain_first");

        // Remaining table vectors back-to-back.
        for (int i = 1; i < tbl.size(); i++) begin
            apply_vec(i);
            in_valid = 1'b1;
            tick(ix);
        end
        drain("drain_table");

        // Eight BYPASS beats streamed against a 1,0,0,1 out_ready pattern.
        sent = 0;
        cyc = 0;
        in_valid = 1'b1;
        while (sent < 8 && cyc < 100) begin
            set_beat(3, 0, sent * 37 - 100, sent, -sent * 1000, 4000 + sent * 20);
            out_ready = pat[cyc % 4];
            tick(ix);
            if (ix) sent++;
            cyc++;
        end
        check("stream_sent", sent, 8);
        drain("drain_stream");

        // Random traffic, modes, clamps and occasional counter clears.
        for (int n = 0; n < 400; n++) begin
            set_beat($urandom_range(0, 3), $urandom_range(0, OMAX), rnd_x(), rnd_x(), rnd_x(), rnd_x());
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 9) < 7);
            sat_clr   = ($urandom_range(0, 19) == 0);
            tick(ix);
        end
        sat_clr = 1'b0;
        drain("drain_random");

        // Mid-stream reset with two beats in flight.
        set_beat(3, 0, 6000, 1, 2, 3);
        out_ready = 1'b0;
        in_valid = 1'b1;
        tick(ix);
        set_beat(3, 0, -6000, 4, 5, 6);
        tick(ix);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_sat_cnt", sat_cnt, 0);
        check("midrst_out_sat", out_sat, 0);
        check("midrst_out_data", out_data, 0);
        exp_q.delete();
        model_cnt = 0;
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("postrst_in_ready", in_ready, 1);
        out_ready = 1'b1;
        set_beat(0, 0, 11, -22, 33, 9999);
        in_valid = 1'b1;
        tick(ix);
        in_valid = 1'b0;
        drain("drain_postrst");

        // Counter saturation, then clear coinciding with a saturating transfer.
        set_beat(3, 0, 5000, 0, 0, 0);
        in_valid = 1'b1;
        out_ready = 1'b1;
        sent = 0;
        cyc = 0;
        while (sent < 65538 && cyc < 70000) begin
            tick(ix);
            if (ix) sent++;
            cyc++;
        end
        in_valid = 1'b0;
        check("long_sent", sent, 65538);
        check("sat_cnt_stuck", sat_cnt, 16'hFFFF);
        sat_clr = 1'b1;
        tick(ix);
        sat_clr = 1'b0;
        check("sat_clr_with_inc", sat_cnt, 1);
        drain("drain_long");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
